// File: rtl/spi_kaydirici_pkg.sv
// -----------------------------------------------------------------------------
// spi_kaydirici_pkg
// Shared constants for the SPI bit engine: default word size, command
// direction codes, FSM state encoding and small direction helpers.
// -----------------------------------------------------------------------------
package spi_kaydirici_pkg;

    // Default bits per transaction word.
    localparam int SPI_TXN_SIZE = 32;

    // Command direction codes. Bit 1 = drive data on MOSI, bit 0 = return RX word.
    localparam logic [1:0] KOMUT_BOS  = 2'b00;
    localparam logic [1:0] KOMUT_OKU  = 2'b01;
    localparam logic [1:0] KOMUT_YAZ  = 2'b10;
    localparam logic [1:0] KOMUT_CIFT = 2'b11;

    typedef enum logic [2:0] {
        BOSTA    = 3'd0,   // idle, ready for a command
        KUR      = 3'd1,   // CSN asserted, first bit set up, one tick wait
        KAYDIR   = 3'd2,   // 2*TXN_BIT SCK edges
        BITIR    = 3'd3,   // end of word; optional tick before CSN release
        CS_BEKLE = 3'd4    // minimum CSN-high time
    } durum_t;

    function automatic logic yon_tx(input logic [1:0] dir);
        return dir[1];
    endfunction

    function automatic logic yon_rx(input logic [1:0] dir);
        return dir[0];
    endfunction

endpackage

// File: rtl/spi_kaydirici_sck_bolucu.sv
// -----------------------------------------------------------------------------
// spi_sck_bolucu
// 16-bit SCK half-period counter. Emits one tick every (div_i+1) clk_i cycles.
// restart_i zeroes the counter so the first tick lands div_i+1 cycles later.
// lead_o tells whether the current tick is a leading SCK edge; it only
// advances on ticks where step_i is high (i.e. ticks that really toggle SCK).
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   restart_i      restart counter, next edge is leading
//   div_i[15:0]    half-period minus one
//   step_i         this tick toggles SCK
//   tick_o         half-period tick (combinational from counter)
//   lead_o         1: current tick is a leading edge, 0: trailing
// -----------------------------------------------------------------------------
module spi_sck_bolucu (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        restart_i,
    input  logic [15:0] div_i,
    input  logic        step_i,
    output logic        tick_o,
    output logic        lead_o
);

    logic [15:0] r_cnt;
    logic        r_lead;
    logic        w_tick;

    assign w_tick = (r_cnt == div_i);
    assign tick_o = w_tick;
    assign lead_o = r_lead;

    always_ff @(posedge clk_i) begin
        if (rst_i || restart_i) begin
            r_cnt  <= 16'd0;
            r_lead <= 1'b1;
        end else if (w_tick) begin
            r_cnt <= 16'd0;
            if (step_i) begin
                r_lead <= ~r_lead;
            end
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/spi_kaydirici.sv
// -----------------------------------------------------------------------------
// spi_kaydirici
// SPI bit engine. Takes one command per valid/ready handshake, shifts the word
// out on MOSI, shifts MISO in, drives CSN/SCK and returns RX words as a
// single-cycle pulse (no backpressure).
//
// Handshake: a command is accepted in a cycle where cmd_valid_i && cmd_ready_o;
// all cmd_* inputs are latched then. cmd_ready_o is registered, high only in
// BOSTA, and low the cycle after an accept. The controller holds the command
// until ready; cmd_valid_i while busy is ignored.
//
// Optional feature macro: SPI_LOOPBACK_EN adds lpbk_i; when high, RX samples
// are taken from the internal MOSI value instead of miso_i.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   cmd_*                   command (data, dir, mode, divider, end-of-frame CS)
//   cmd_ready_o             engine accepts a command
//   recv_data_o/_valid_o    received word and its one-cycle pulse
//   miso_i/mosi_o/csn_o/sck_o  SPI pins
// -----------------------------------------------------------------------------
module spi_kaydirici
    import spi_kaydirici_pkg::*;
#(
    parameter int TXN_BIT = SPI_TXN_SIZE
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cmd_msb_first_i,
    input  logic [TXN_BIT-1:0] cmd_data_i,
    input  logic               cmd_valid_i,
    input  logic               cmd_cpha_i,
    input  logic               cmd_cpol_i,
    input  logic [15:0]        cmd_sck_div_i,
    input  logic               cmd_end_cs_i,
    input  logic [1:0]         cmd_dir_i,
    output logic               cmd_ready_o,
    output logic [TXN_BIT-1:0] recv_data_o,
    output logic               recv_data_valid_o,
    input  logic               miso_i,
    output logic               mosi_o,
    output logic               csn_o,
`ifdef SPI_LOOPBACK_EN
    input  logic               lpbk_i,
`endif
    output logic               sck_o
);

    localparam int KW = (2 * TXN_BIT > 2) ? $clog2(2 * TXN_BIT) : 1;
    localparam logic [KW-1:0] SON_KENAR = KW'(2 * TXN_BIT - 1);

    durum_t             r_durum;
    logic               r_ready;
    logic               r_csn;
    logic               r_sck;
    logic               r_mosi;
    logic [TXN_BIT-1:0] r_recv;
    logic               r_recv_vld;
    logic               r_msb;
    logic               r_cpha;
    logic               r_cpol;
    logic [15:0]        r_div;
    logic               r_end_cs;
    logic [1:0]         r_dir;
    logic [TXN_BIT-1:0] r_tx;
    logic [TXN_BIT-1:0] r_rx;
    logic [KW-1:0]      r_kenar;

    logic               w_accept;
    logic               w_tick;
    logic               w_lead;
    logic               w_step;
    logic               w_ilk_kenar;
    logic               w_son_kenar;
    logic               w_ornek;
    logic               w_kaydir;
    logic               w_rx_bit;
    logic               w_ilk_bit;
    logic [TXN_BIT-1:0] w_tx_next;
    logic [TXN_BIT-1:0] w_rx_next;

    assign w_accept    = cmd_valid_i && r_ready;
    assign w_step      = (r_durum == KAYDIR);
    assign w_ilk_kenar = (r_kenar == '0);
    assign w_son_kenar = (r_kenar == SON_KENAR);

    // CPHA=0: sample leading, shift trailing (the last trailing edge has no
    // next bit). CPHA=1: shift leading, sample trailing; the first leading
    // edge shifts nothing because bit 0 was already set up at accept.
    assign w_ornek  = w_tick && w_step && (r_cpha ? !w_lead : w_lead);
    assign w_kaydir = w_tick && w_step &&
                      (r_cpha ? (w_lead && !w_ilk_kenar) : (!w_lead && !w_son_kenar));

`ifdef SPI_LOOPBACK_EN
    assign w_rx_bit = lpbk_i ? r_mosi : miso_i;
`else
    assign w_rx_bit = miso_i;
`endif

    assign w_ilk_bit = yon_tx(cmd_dir_i)
                       ? (cmd_msb_first_i ? cmd_data_i[TXN_BIT-1] : cmd_data_i[0])
                       : 1'b1;
    assign w_tx_next = r_msb ? (r_tx << 1) : (r_tx >> 1);

    // LSB-first words enter from the top so the first bit ends in bit 0.
    always_comb begin
        w_rx_next = r_rx;
        if (w_ornek) begin
            if (r_msb) begin
                w_rx_next = {r_rx[TXN_BIT-2:0], w_rx_bit};
            end else begin
                w_rx_next = {w_rx_bit, r_rx[TXN_BIT-1:1]};
            end
        end
    end

    spi_sck_bolucu u_bolucu (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .restart_i (w_accept),
        .div_i     (r_div),
        .step_i    (w_step),
        .tick_o    (w_tick),
        .lead_o    (w_lead)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_durum    <= BOSTA;
            r_ready    <= 1'b0;
            r_csn      <= 1'b1;
            r_sck      <= 1'b0;
            r_mosi     <= 1'b1;
            r_recv     <= '0;
            r_recv_vld <= 1'b0;
            r_msb      <= 1'b1;
            r_cpha     <= 1'b0;
            r_cpol     <= 1'b0;
            r_div      <= 16'd0;
            r_end_cs   <= 1'b1;
            r_dir      <= KOMUT_BOS;
            r_tx       <= '0;
            r_rx       <= '0;
            r_kenar    <= '0;
        end else begin
            r_ready    <= 1'b0;
            r_recv_vld <= 1'b0;
            case (r_durum)
                BOSTA: begin
                    r_ready <= !w_accept;
                    if (w_accept) begin
                        r_msb    <= cmd_msb_first_i;
                        r_cpha   <= cmd_cpha_i;
                        r_cpol   <= cmd_cpol_i;
                        r_div    <= cmd_sck_div_i;
                        r_end_cs <= cmd_end_cs_i;
                        r_dir    <= cmd_dir_i;
                        r_tx     <= cmd_data_i;
                        r_rx     <= '0;
                        r_kenar  <= '0;
                        r_sck    <= cmd_cpol_i;
                        r_mosi   <= w_ilk_bit;
                        r_csn    <= 1'b0;
                        // CSN still low from a previous word: no setup tick.
                        r_durum  <= r_csn ? KUR : KAYDIR;
                    end
                end
                KUR: begin
                    if (w_tick) begin
                        r_durum <= KAYDIR;
                    end
                end
                KAYDIR: begin
                    if (w_tick) begin
                        r_sck   <= ~r_sck;
                        r_kenar <= r_kenar + 1'b1;
                        r_rx    <= w_rx_next;
                        if (w_kaydir) begin
                            r_tx   <= w_tx_next;
                            r_mosi <= yon_tx(r_dir)
                                      ? (r_msb ? w_tx_next[TXN_BIT-1] : w_tx_next[0])
                                      : 1'b1;
                        end
                        if (w_son_kenar) begin
                            r_kenar <= '0;
                            r_durum <= BITIR;
                            if (yon_rx(r_dir)) begin
                                r_recv     <= w_rx_next;
                                r_recv_vld <= 1'b1;
                            end
                        end
                    end
                end
                BITIR: begin
                    if (!r_end_cs) begin
                        r_durum <= BOSTA;
                    end else if (w_tick) begin
                        r_csn   <= 1'b1;
                        r_mosi  <= 1'b1;
                        r_durum <= CS_BEKLE;
                    end
                end
                CS_BEKLE: begin
                    if (w_tick) begin
                        r_durum <= BOSTA;
                    end
                end
                default: begin
                    r_durum <= BOSTA;
                end
            endcase
        end
    end

    assign cmd_ready_o       = r_ready;
    assign recv_data_o       = r_recv;
    assign recv_data_valid_o = r_recv_vld;
    assign mosi_o            = r_mosi;
    assign csn_o             = r_csn;
    assign sck_o             = r_sck;

endmodule

// File: tb/tb_spi_kaydirici.sv
module tb_spi_kaydirici;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_msb_first;
    logic [W-1:0] cmd_data;
    logic         cmd_valid;
    logic         cmd_cpha;
    logic         cmd_cpol;
    logic [15:0]  cmd_sck_div;
    logic         cmd_end_cs;
    logic [1:0]   cmd_dir;
    logic         cmd_ready;
    logic [W-1:0] recv_data;
    logic         recv_valid;
    logic         miso;
    logic         mosi;
    logic         csn;
    logic         sck;
`ifdef SPI_LOOPBACK_EN
    logic         lpbk;
`endif

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    spi_kaydirici #(.TXN_BIT(W)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .cmd_msb_first_i   (cmd_msb_first),
        .cmd_data_i        (cmd_data),
        .cmd_valid_i       (cmd_valid),
        .cmd_cpha_i        (cmd_cpha),
        .cmd_cpol_i        (cmd_cpol),
        .cmd_sck_div_i     (cmd_sck_div),
        .cmd_end_cs_i      (cmd_end_cs),
        .cmd_dir_i         (cmd_dir),
        .cmd_ready_o       (cmd_ready),
        .recv_data_o       (recv_data),
        .recv_data_valid_o (recv_valid),
        .miso_i            (miso),
        .mosi_o            (mosi),
        .csn_o             (csn),
`ifdef SPI_LOOPBACK_EN
        .lpbk_i            (lpbk),
`endif
        .sck_o             (sck)
    );

    // ---------------- checker ----------------
    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- monitor + slave model ----------------
    int           cyc = 0;
    int           acc_cyc = 0;
    int           vld_cnt, vld_rel, csn_rise_rel, rdy_rel, tog_cnt, last_tog, hp;
    int           csn_rise_total = 0;
    logic [W-1:0] rx_got = '0;
    logic         mosi_zero;
    logic         mosi_q[$];
    logic         prev_csn = 1'b1;
    logic         prev_sck = 1'b0;
    logic         sl_cpha = 1'b0;
    logic         sl_msb = 1'b1;
    logic [W-1:0] sl_word = '0;
    int           sl_k = 0;

    function automatic logic slave_bit(input logic [W-1:0] word, input logic msb, input int k);
        if (k >= W) return 1'b0;
        return msb ? word[W-1-k] : word[k];
    endfunction

    function automatic logic [31:0] q_val();
        logic [31:0] v = '0;
        foreach (mosi_q[i]) v = {v[30:0], mosi_q[i]};
        return v;
    endfunction

    always @(negedge clk) begin
        int rel;
        cyc++;
        rel = cyc - acc_cyc;
        if (recv_valid) begin
            vld_cnt++;
            if (vld_cnt == 1) vld_rel = rel;
            rx_got = recv_data;
        end
        if (csn && !prev_csn) begin
            csn_rise_total++;
            csn_rise_rel = rel;
        end
        if (cmd_ready && rdy_rel < 0 && rel > 0) rdy_rel = rel;
        if (!csn && !mosi) mosi_zero = 1'b1;
        if (sck && !prev_sck && !csn) mosi_q.push_back(mosi);
        if (!csn && !prev_csn && sck != prev_sck) begin
            if (tog_cnt == 1) hp = cyc - last_tog;
            tog_cnt++;
            last_tog = cyc;
        end
        // Slave: CPHA=0 presents bit 0 at CSN fall and changes on trailing
        // edges; CPHA=1 changes on leading edges.
        if (prev_csn && !csn) begin
            sl_k = 0;
            if (!sl_cpha) miso = slave_bit(sl_word, sl_msb, 0);
        end else if (!csn && sck != prev_sck) begin
            sl_k++;
            if (!sl_cpha && (sl_k % 2 == 0)) miso = slave_bit(sl_word, sl_msb, sl_k / 2);
            else if (sl_cpha && (sl_k % 2 == 1)) miso = slave_bit(sl_word, sl_msb, (sl_k - 1) / 2);
        end
        prev_csn = csn;
        prev_sck = sck;
    end

    // ---------------- driver tasks ----------------
    task automatic send_cmd(input logic [W-1:0] data, input logic [1:0] dir, input logic msb,
                            input logic cpol, input logic cpha, input logic [15:0] div,
                            input logic end_cs);
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!cmd_ready && n < 300);
        if (!cmd_ready) begin
            check_val("ready_timeout", 32'(cmd_ready), 32'd1);
            return;
        end
        cmd_data      = data;
        cmd_dir       = dir;
        cmd_msb_first = msb;
        cmd_cpol      = cpol;
        cmd_cpha      = cpha;
        cmd_sck_div   = div;
        cmd_end_cs    = end_cs;
        cmd_valid     = 1'b1;
        acc_cyc       = cyc;
        vld_cnt       = 0;
        vld_rel       = -1;
        csn_rise_rel  = -1;
        rdy_rel       = -1;
        mosi_zero     = 1'b0;
        tog_cnt       = 0;
        hp            = 0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!cmd_ready && n < 2000);
        if (!cmd_ready) check_val("idle_timeout", 32'(cmd_ready), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst           = 1'b1;
        cmd_valid     = 1'b0;
        cmd_data      = '0;
        cmd_dir       = 2'b00;
        cmd_msb_first = 1'b1;
        cmd_cpol      = 1'b0;
        cmd_cpha      = 1'b0;
        cmd_sck_div   = 16'd0;
        cmd_end_cs    = 1'b1;
        miso          = 1'b0;
`ifdef SPI_LOOPBACK_EN
        lpbk          = 1'b0;
`endif

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_val("rst_csn",   32'(csn), 32'd1);
        check_val("rst_sck",   32'(sck), 32'd0);
        check_val("rst_mosi",  32'(mosi), 32'd1);
        check_val("rst_ready", 32'(cmd_ready), 32'd0);
        check_val("rst_valid", 32'(recv_valid), 32'd0);
        check_val("rst_recv",  32'(recv_data), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check_val("ready_after_rst", 32'(cmd_ready), 32'd1);

        // Mode 0 YAZ 0xA5, MSB first, div 0, end_cs
        mosi_q.delete();
        send_cmd(8'hA5, 2'b10, 1'b1, 1'b0, 1'b0, 16'd0, 1'b1);
        wait_idle();
        check_val("m0_mosi_bits",  q_val(), 32'hA5);
        check_val("m0_mosi_count", 32'(mosi_q.size()), 32'd8);
        check_val("m0_no_valid",   32'(vld_cnt), 32'd0);
        check_val("m0_csn_rise",   32'(csn_rise_rel), 32'd19);
        check_val("m0_ready_lat",  32'(rdy_rel), 32'd21);
        check_val("m0_sck_idle",   32'(sck), 32'd0);
        check_val("m0_mosi_idle",  32'(mosi), 32'd1);

        // Mode 3 OKU, slave returns 0x3C MSB first
        sl_cpha = 1'b1; sl_msb = 1'b1; sl_word = 8'h3C;
        send_cmd(8'h00, 2'b01, 1'b1, 1'b1, 1'b1, 16'd0, 1'b1);
        wait_idle();
        check_val("m3_rx",        32'(rx_got), 32'h3C);
        check_val("m3_valid_cnt", 32'(vld_cnt), 32'd1);
        check_val("m3_valid_lat", 32'(vld_rel), 32'd18);
        check_val("m3_mosi_ones", 32'(mosi_zero), 32'd0);
        check_val("m3_sck_idle",  32'(sck), 32'd1);

        // LSB-first full duplex, TX 0x01, slave returns 0x80
        sl_cpha = 1'b0; sl_msb = 1'b0; sl_word = 8'h80;
        mosi_q.delete();
        send_cmd(8'h01, 2'b11, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1);
        wait_idle();
        check_val("lsb_first_bit", 32'(mosi_q.size() > 0 ? mosi_q[0] : 1'b0), 32'd1);
        check_val("lsb_mosi_bits", q_val(), 32'h80);
        check_val("lsb_rx",        32'(rx_got), 32'h80);

        // Two words, CSN held low across them
        csn_rise_total = 0;
        mosi_q.delete();
        send_cmd(8'h5A, 2'b10, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
        wait_idle();
        check_val("hold_csn_low", 32'(csn), 32'd0);
        send_cmd(8'hC3, 2'b10, 1'b1, 1'b0, 1'b0, 16'd0, 1'b1);
        wait_idle();
        check_val("hold_mosi_bits", q_val(), 32'h5AC3);
        check_val("hold_csn_rises", 32'(csn_rise_total), 32'd1);
        check_val("hold_csn_lat",   32'(csn_rise_rel), 32'd18);
        check_val("recv_hold",      32'(recv_data), 32'h80);

        // div=3, mode 1 OKU, reset in the middle of the word
        sl_cpha = 1'b1; sl_msb = 1'b1; sl_word = 8'hFF;
        send_cmd(8'h00, 2'b01, 1'b1, 1'b0, 1'b1, 16'd3, 1'b1);
        repeat (20) @(negedge clk);
        #1;
        check_val("div3_half_period", 32'(hp), 32'd4);
        check_val("mid_csn_low",      32'(csn), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_val("mid_rst_csn",   32'(csn), 32'd1);
        check_val("mid_rst_sck",   32'(sck), 32'd0);
        check_val("mid_rst_mosi",  32'(mosi), 32'd1);
        check_val("mid_rst_ready", 32'(cmd_ready), 32'd0);
        check_val("mid_rst_valid", 32'(recv_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check_val("mid_rst_ready_after", 32'(cmd_ready), 32'd1);
        repeat (80) @(negedge clk);
        check_val("mid_rst_no_pulse", 32'(vld_cnt), 32'd0);

`ifdef SPI_LOOPBACK_EN
        // Loopback: RX follows internal MOSI, slave drives 0
        lpbk = 1'b1;
        sl_cpha = 1'b0; sl_msb = 1'b1; sl_word = 8'h00;
        send_cmd(8'hEF, 2'b11, 1'b1, 1'b0, 1'b0, 16'd0, 1'b1);
        wait_idle();
        check_val("lpbk_rx", 32'(rx_got), 32'hEF);
        lpbk = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit
    initial begin
        #500000;
        $display("FAIL global_timeout: got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/spi_kaydirici.md
Name: spi_kaydirici

Overview:
SPI bit-engine directly downstream of the memory-mapped SPI controller.
- Accepts one transaction command per handshake: data word, direction, mode, SCK divider and end-of-frame CS flag.
- Serialises the word on MOSI, deserialises MISO, and drives CSN/SCK.
- Returns received words to the controller's MISO FIFO path as a single-cycle pulse.

Parameters:
TXN_BIT, 32 (`SPI_TXN_SIZE), bits per transaction word.

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous, active-high reset
cmd_msb_first_i  in  1  1: MSB first for TX and RX; 0: LSB first
cmd_data_i  in  TXN_BIT  TX word
cmd_valid_i  in  1  command valid
cmd_cpha_i  in  1  clock phase
cmd_cpol_i  in  1  clock idle level
cmd_sck_div_i  in  16  SCK half-period minus one, in clk_i cycles
cmd_end_cs_i  in  1  deassert CSN after this word
cmd_dir_i  in  2  00 BOS, 01 OKU, 10 YAZ, 11 full-duplex
cmd_ready_o  out  1  engine accepts a command
recv_data_o  out  TXN_BIT  received word
recv_data_valid_o  out  1  one-cycle pulse; no backpressure
miso_i  in  1  serial in
mosi_o  out  1  serial out
csn_o  out  1  chip select, active low
sck_o  out  1  serial clock

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high on rst_i.
- Reset values (also the response to rst_i mid-transaction, taking effect on the next clk_i edge):
  - csn_o=1, sck_o=0, mosi_o=1
  - cmd_ready_o=0, recv_data_o=0, recv_data_valid_o=0
  - FSM in BOSTA, latched cpol=0
- cmd_ready_o: rises in the first cycle after reset release. High only in BOSTA.
- Accept and latch: a command is accepted when cmd_valid_i && cmd_ready_o. All cmd_* inputs are latched that cycle. cmd_ready_o drops the next cycle.
- Half-period tick: one pulse every (sck_div+1) clk_i cycles; the counter restarts at accept. sck_div=0 gives SCK = clk/2; sck_div=0xFFFF gives a 65536-cycle half-period.
- FSM states and transitions:
  - BOSTA -> KUR if csn_o=1; BOSTA -> KAYDIR if csn_o=0 (CS still held from the previous word).
  - KUR: drive csn_o=0, sck_o=cpol, put the first bit on MOSI; wait one tick, then go to KAYDIR.
  - KAYDIR: 2*TXN_BIT ticks, each toggling sck_o.
    - CPHA=0: sample on odd (leading) edges, shift on even edges. The first bit is already set up before the first edge.
    - CPHA=1: shift on leading edges, sample on trailing edges.
  - BITIR: if end_cs, wait one tick, then csn_o=1, then wait one tick minimum CS-high time, then go to BOSTA. If not end_cs, go to BOSTA immediately with csn_o held at 0.
- sck_o idles at the latched cpol. When cpol changes while CSN is low, sck_o moves to the new cpol level on accept.
- MOSI source: for YAZ/11, MOSI carries cmd_data_i in the selected bit order. For OKU/BOS, MOSI carries all 1s. mosi_o=1 whenever csn_o=1.
- RX bit order: for LSB-first, bits are assembled so that recv_data_o is in natural order.
- recv_data_valid_o: pulses for OKU and 11 only, in the cycle after the final SCK edge. recv_data_o holds its value until the next pulse.
- Latency, TXN_BIT=8, div=0, CS initially high, end_cs=1: accept at cycle 0; KUR 1 cycle; 16 SCK-edge cycles; valid pulse at cycle 18; csn_o rises at cycle 19; cmd_ready_o=1 at cycle 21.
- cmd_valid_i while busy is ignored. The controller holds the command until ready.

Optional Feature:
SPI_LOOPBACK_EN
- Defined: adds input port lpbk_i (1 bit). When lpbk_i=1, the sampled bit is taken from the internal MOSI value instead of miso_i. miso_i is ignored.
- Undefined: port absent; sampling always from miso_i.

Decomposition:
- Shared header sabitler.vh: `SPI_TXN_SIZE, direction codes KOMUT_BOS/OKU/YAZ/CIFT, FSM state encodings.
- Sub-module spi_sck_bolucu: 16-bit half-period counter with restart input. Outputs the tick pulse and a leading/trailing edge flag.

Test Plan:
- Mode 0, div=0, TXN_BIT=8, YAZ 0xA5, msb_first, end_cs=1 -> MOSI 1,0,1,0,0,1,0,1 valid at SCK rising edges; no valid pulse; csn_o returns high.
- Mode 3 OKU, slave model drives 0x3C -> recv_data_o=0x3C with a single valid pulse; MOSI stays 1 throughout.
- LSB-first full-duplex, TX 0x01, slave returns 0x80 LSB-first -> first MOSI bit is 1; recv_data_o=0x80.
- Two commands, first end_cs=0, second end_cs=1 -> csn_o stays low across both; rises only after the second word.
- div=3 -> SCK half-period exactly 4 clk_i cycles; rst_i asserted mid-KAYDIR -> next edge gives csn_o=1, sck_o=0, no valid pulse, ready 1 cycle after release.
- SPI_LOOPBACK_EN defined, lpbk_i=1, full-duplex 0xDEADBEEF (TXN_BIT=32) -> recv_data_o=0xDEADBEEF with miso_i tied to 0.
